// File: rtl/sap1_pkg.sv
// Shared SAP-1 definitions: control-word bit positions, idle word,
// opcodes and one-hot T-state encodings used by the controller and datapath.
package sap1_pkg;

    // Control word bit positions, MSB first
    localparam int CON_CP  = 11;
    localparam int CON_EP  = 10;
    localparam int CON_NLM = 9;
    localparam int CON_NCE = 8;
    localparam int CON_NLI = 7;
    localparam int CON_NEI = 6;
    localparam int CON_NLA = 5;
    localparam int CON_EA  = 4;
    localparam int CON_SU  = 3;
    localparam int CON_EU  = 2;
    localparam int CON_NLB = 1;
    localparam int CON_NLO = 0;

    // Every active-low line high, every active-high line low
    localparam logic [11:0] CON_IDLE = 12'h3E3;

    // Instruction opcodes (IR[7:4])
    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    // One-hot T-state ring encodings
    localparam logic [5:0] T1 = 6'b000001;
    localparam logic [5:0] T2 = 6'b000010;
    localparam logic [5:0] T3 = 6'b000100;
    localparam logic [5:0] T4 = 6'b001000;
    localparam logic [5:0] T5 = 6'b010000;
    localparam logic [5:0] T6 = 6'b100000;

    // True when exactly one bit of the ring is set
    function automatic logic is_onehot6(input logic [5:0] v);
        return (v != 6'd0) && ((v & (v - 6'd1)) == 6'd0);
    endfunction

endpackage

// File: rtl/sap1_ring_counter.sv
// Six-state one-hot T-cycle ring with synchronous active-low reset,
// hold (freeze) and jump-to-T1 controls. Illegal codes self-recover to T1.
module sap1_ring_counter
    import sap1_pkg::*;
(
    input  logic       CLK,
    input  logic       nCLR,
    input  logic       hold,
    input  logic       jump,
    output logic [5:0] tstate
);

    // Advance, hold or restart the ring; reset and bad encodings go to T1
    always_ff @(posedge CLK) begin
        if (!nCLR) begin
            tstate <= T1;
        end else if (!is_onehot6(tstate)) begin
            tstate <= T1;
        end else if (hold) begin
            tstate <= tstate;
        end else if (jump) begin
            tstate <= T1;
        end else begin
            tstate <= {tstate[4:0], tstate[5]};
        end
    end

endmodule

// File: rtl/sap1_controller_sequencer.sv
// SAP-1 controller/sequencer: drives the T-state ring, decodes the opcode
// into the 12-bit control word and latches HALT on an HLT instruction.
// TSTATE doubles as the state debug output of the sequencer.
module sap1_controller_sequencer
    import sap1_pkg::*;
#(
    parameter bit SKIP_IDLE = 1'b0
) (
    input  logic        CLK,
    input  logic        nCLR,
    input  logic [3:0]  OPCODE,
    output logic [11:0] CON,
    output logic [5:0]  TSTATE,
    output logic        HALT
);

    logic jump;
    logic is_lda;
    logic is_add;
    logic is_sub;
    logic is_out;
    logic is_hlt;
    logic is_nop;

    // Opcode classification; only consulted in T4-T6 where OPCODE is stable
    always_comb begin
        is_lda = (OPCODE == OP_LDA);
        is_add = (OPCODE == OP_ADD);
        is_sub = (OPCODE == OP_SUB);
        is_out = (OPCODE == OP_OUT);
        is_hlt = (OPCODE == OP_HLT);
        is_nop = !(is_lda || is_add || is_sub || is_out || is_hlt);
    end

    // Early return to T1 skips idle T-states when enabled
    always_comb begin
        jump = 1'b0;
        if (SKIP_IDLE) begin
            if ((TSTATE == T4) && (is_out || is_nop)) jump = 1'b1;
            if ((TSTATE == T5) && is_lda)             jump = 1'b1;
        end
    end

    sap1_ring_counter u_ring (
        .CLK    (CLK),
        .nCLR   (nCLR),
        .hold   (HALT),
        .jump   (jump),
        .tstate (TSTATE)
    );

    // HALT latches at the T4 edge of an HLT and clears only through reset
    always_ff @(posedge CLK) begin
        if (!nCLR) begin
            HALT <= 1'b0;
        end else if ((TSTATE == T4) && is_hlt) begin
            HALT <= 1'b1;
        end
    end

    // Control word decode: zero latency from TSTATE/OPCODE/HALT
    always_comb begin
        CON = CON_IDLE;
        if (nCLR && !HALT) begin
            case (TSTATE)
                T1: begin
                    CON[CON_EP]  = 1'b1;
                    CON[CON_NLM] = 1'b0;
                end
                T2: begin
                    CON[CON_CP]  = 1'b1;
                end
                T3: begin
                    CON[CON_NCE] = 1'b0;
                    CON[CON_NLI] = 1'b0;
                end
                T4: begin
                    if (is_lda || is_add || is_sub) begin
                        CON[CON_NLM] = 1'b0;
                        CON[CON_NEI] = 1'b0;
                    end else if (is_out) begin
                        CON[CON_EA]  = 1'b1;
                        CON[CON_NLO] = 1'b0;
                    end
                end
                T5: begin
                    if (is_lda) begin
                        CON[CON_NCE] = 1'b0;
                        CON[CON_NLA] = 1'b0;
                    end else if (is_add || is_sub) begin
                        CON[CON_NCE] = 1'b0;
                        CON[CON_NLB] = 1'b0;
                    end
                end
                T6: begin
                    if (is_add || is_sub) begin
                        CON[CON_EU]  = 1'b1;
                        CON[CON_NLA] = 1'b0;
                        CON[CON_SU]  = is_sub;
                    end
                end
                default: CON = CON_IDLE;
            endcase
        end
    end

endmodule
